jit_emit_seq: RTL and testbench

- Sequencer between the bytecode decoder and the ARM code buffer.
- For each translated JVM bytecode it walks a run of consecutive template indices into the instruction-template ROM (7-bit index in, 32-bit ARM word out, combinational).
- It patches at most one word per run, either with an immediate or with a branch offset.
- It streams the resulting words, with their code addresses, to the code-buffer writer over a valid/ready handshake.

---
 rtl/jit_pkg.sv | 21 ++
 rtl/jit_patch_unit.sv | 37 +++
 rtl/jit_emit_seq.sv | 198 +++++++++++++++++++
 tb/tb_jit_emit_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/jit_pkg.sv
// Shared constants and types for the JIT template emitter: patch modes,
// sequencer states and the template ROM sentinel.
`timescale 1ns/1ps
package jit_pkg;
  localparam int IDX_W_DEF  = 7;
  localparam int CNT_W_DEF  = 4;
  localparam int ADDR_W_DEF = 32;

  localparam logic [1:0] PM_NONE  = 2'd0;
  localparam logic [1:0] PM_IMM12 = 2'd1;
  localparam logic [1:0] PM_BR24  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] TPL_UNMAPPED = 32'hFFFF_FFFF;
  localparam logic [31:0] ARM_PC_BIAS  = 32'd8;
endpackage

// File: rtl/jit_patch_unit.sv
// Combinational patcher: inserts a 12-bit immediate or a PC-relative
// 24-bit branch word offset into a template word.
`timescale 1ns/1ps
import jit_pkg::*;

module jit_patch_unit #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [31:0]       rom_word,
  input  logic [1:0]        mode,
  input  logic [11:0]       imm,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       patched
);

  // ARM reads PC as the instruction address plus 8; offset is in words.
  function automatic logic [23:0] br24_offset(input logic [ADDR_W-1:0] tgt,
                                              input logic [ADDR_W-1:0] pc);
    logic [ADDR_W-1:0] diff;
    logic [ADDR_W-1:0] shifted;
    diff    = tgt - (pc + ADDR_W'(ARM_PC_BIAS));
    shifted = ADDR_W'($signed(diff) >>> 2);
    return shifted[23:0];
  endfunction

  // Select the patch form; reserved mode passes the template through.
  always_comb begin
    patched = rom_word;
    case (mode)
      PM_IMM12: patched = {rom_word[31:12], imm};
      PM_BR24:  patched = {rom_word[31:24], br24_offset(target, addr)};
      default:  patched = rom_word;
    endcase
  end

endmodule

// File: rtl/jit_emit_seq.sv
// Template run sequencer: walks consecutive ROM indices for one bytecode,
// patches at most one word and streams words with code addresses.
`timescale 1ns/1ps
import jit_pkg::*;

module jit_emit_seq #(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_first,
  input  logic [CNT_W-1:0]  req_count,
  input  logic [1:0]        req_pmode,
  input  logic [CNT_W-1:0]  req_pidx,
  input  logic [11:0]       req_imm,
  input  logic [ADDR_W-1:0] req_target,
  output logic [IDX_W-1:0]  rom_addr,
  input  logic [31:0]       rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              err
);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0]  pos_r, pos_s;
  logic [CNT_W-1:0]  last_r, last_s;
  logic [1:0]        pmode_r, pmode_s;
  logic [CNT_W-1:0]  pidx_r, pidx_s;
  logic [11:0]       imm_r, imm_s;
  logic [ADDR_W-1:0] target_r, target_s;
  logic [IDX_W-1:0]  rom_addr_r, rom_addr_s;
  logic              out_valid_r, out_valid_s;
  logic [31:0]       out_data_r, out_data_s;
  logic [ADDR_W-1:0] out_addr_r, out_addr_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              req_ready_r, req_ready_s;
  logic [1:0]        patch_mode_s;
  logic [31:0]       patched_s;
  logic              can_cap_s;

  // Only the selected position of the run receives the patch.
  always_comb begin
    patch_mode_s = PM_NONE;
    if (pos_r == pidx_r) begin
      patch_mode_s = pmode_r;
    end else begin
      patch_mode_s = PM_NONE;
    end
  end

  jit_patch_unit #(.ADDR_W(ADDR_W)) u_patch (
    .rom_word (rom_data),
    .mode     (patch_mode_s),
    .imm      (imm_r),
    .target   (target_r),
    .addr     (cnt_r),
    .patched  (patched_s)
  );

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    pos_s       = pos_r;
    last_s      = last_r;
    pmode_s     = pmode_r;
    pidx_s      = pidx_r;
    imm_s       = imm_r;
    target_s    = target_r;
    rom_addr_s  = rom_addr_r;
    out_data_s  = out_data_r;
    out_addr_s  = out_addr_r;
    done_s      = 1'b0;
    err_s       = err_r;
    req_ready_s = req_ready_r;
    can_cap_s   = !out_valid_r || out_ready;

    // A word accepted this cycle leaves the output register.
    if (out_valid_r && out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end

    case (state_r)
      IDLE: begin
        if (base_load) begin
          cnt_s = base_addr & ~ADDR_W'(3);
        end else if (req_valid) begin
          pmode_s     = req_pmode;
          pidx_s      = req_pidx;
          imm_s       = req_imm;
          target_s    = req_target;
          rom_addr_s  = req_first;
          pos_s       = {CNT_W{1'b0}};
          last_s      = (req_count == {CNT_W{1'b0}}) ? {CNT_W{1'b0}}
                                                     : req_count - CNT_W'(1);
          req_ready_s = 1'b0;
          state_s     = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (can_cap_s) begin
          if (rom_data == TPL_UNMAPPED) begin
            err_s   = 1'b1;
            state_s = DONE;
          end else begin
            out_valid_s = 1'b1;
            out_data_s  = patched_s;
            out_addr_s  = cnt_r;
            cnt_s       = cnt_r + ADDR_W'(4);
            pos_s       = pos_r + CNT_W'(1);
            rom_addr_s  = rom_addr_r + IDX_W'(1);
            if (pos_r == last_r) begin
              state_s = DONE;
            end else begin
              state_s = EMIT;
            end
          end
        end else begin
          state_s = EMIT;
        end
      end
      DONE: begin
        if (can_cap_s) begin
          done_s      = 1'b1;
          req_ready_s = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        req_ready_s = 1'b1;
        state_s     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {ADDR_W{1'b0}};
      pos_r       <= {CNT_W{1'b0}};
      last_r      <= {CNT_W{1'b0}};
      pmode_r     <= PM_NONE;
      pidx_r      <= {CNT_W{1'b0}};
      imm_r       <= 12'd0;
      target_r    <= {ADDR_W{1'b0}};
      rom_addr_r  <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      out_addr_r  <= {ADDR_W{1'b0}};
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      pos_r       <= pos_s;
      last_r      <= last_s;
      pmode_r     <= pmode_s;
      pidx_r      <= pidx_s;
      imm_r       <= imm_s;
      target_r    <= target_s;
      rom_addr_r  <= rom_addr_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      out_addr_r  <= out_addr_s;
      done_r      <= done_s;
      err_r       <= err_s;
      req_ready_r <= req_ready_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rom_addr  = rom_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_addr  = out_addr_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_jit_emit_seq.sv
// Directed self-checking bench for jit_emit_seq with a small template ROM model.
`timescale 1ns/1ps
module tb_jit_emit_seq;
  localparam int IDX_W  = 7;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              base_load = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [IDX_W-1:0]  req_first = '0;
  logic [CNT_W-1:0]  req_count = '0;
  logic [1:0]        req_pmode = '0;
  logic [CNT_W-1:0]  req_pidx = '0;
  logic [11:0]       req_imm = '0;
  logic [ADDR_W-1:0] req_target = '0;
  logic [IDX_W-1:0]  rom_addr;
  logic [31:0]       rom_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  jit_emit_seq #(.IDX_W(IDX_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_first(req_first),
    .req_count(req_count), .req_pmode(req_pmode), .req_pidx(req_pidx),
    .req_imm(req_imm), .req_target(req_target), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (rom_addr)
      7'h01:   rom_data = 32'hE49D0004;
      7'h02:   rom_data = 32'hE52D0004;
      7'h03:   rom_data = 32'hE8BD0003;
      7'h22:   rom_data = 32'hC3A00000;
      7'h2C:   rom_data = 32'hEB000000;
      7'h42:   rom_data = 32'hED800B00;
      7'h43:   rom_data = 32'hFFFFFFFF;
      default: rom_data = 32'h00000000;
    endcase
  end

  always @(negedge clk) if (out_valid && out_ready) hs_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [6:0] first, input logic [3:0] count,
                          input logic [1:0] pmode, input logic [3:0] pidx,
                          input logic [11:0] imm, input logic [31:0] target);
    req_first = first; req_count = count; req_pmode = pmode;
    req_pidx = pidx; req_imm = imm; req_target = target;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0 || out_addr !== 32'h0) begin errors++; $display("FAIL reset_out: got %h@%h expected 0@0", out_data, out_addr); end
    checks++; if (done !== 1'b0 || err !== 1'b0 || rom_addr !== 7'h0) begin errors++; $display("FAIL reset_misc: got done=%b err=%b rom_addr=%h expected 0 0 0", done, err, rom_addr); end
    rst = 1'b0;
  endtask

  task automatic test_basic_run();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hE49D0004; exp_d[1] = 32'hE52D0004; exp_d[2] = 32'hE8BD0003;
    base_load = 1'b1; base_addr = 32'h100;
    step();
    base_load = 1'b0;
    send_req(7'h01, 4'd3, 2'd0, 4'd0, 12'h0, 32'h0);
    checks++; if (req_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got ready=%b valid=%b expected 0 0", req_ready, out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_addr !== 32'h100 + 32'(4 * i) || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_word%0d: got v=%b %h@%h done=%b expected 1 %h@%h 0", i, out_valid, out_data, out_addr, done, exp_d[i], 32'h100 + 32'(4 * i));
      end
    end
    step();
    checks++; if (done !== 1'b1 || out_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL basic_done: got done=%b valid=%b ready=%b expected 1 0 1", done, out_valid, req_ready); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_imm_patch();
    send_req(7'h22, 4'd1, 2'd1, 4'd0, 12'h005, 32'h0);
    step();
    checks++; if (out_data !== 32'hC3A00005 || out_addr !== 32'h10C) begin errors++; $display("FAIL imm_patch: got %h@%h expected C3A00005@0000010c", out_data, out_addr); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL imm_done: got %b expected 1", done); end
    step();
    send_req(7'h22, 4'd1, 2'd1, 4'd1, 12'h005, 32'h0);
    step();
    checks++; if (out_data !== 32'hC3A00000 || out_addr !== 32'h110) begin errors++; $display("FAIL imm_pidx_out_of_run: got %h@%h expected C3A00000@00000110", out_data, out_addr); end
    step(); step();
    send_req(7'h22, 4'd0, 2'd3, 4'd0, 12'h005, 32'h0);
    step();
    checks++; if (out_data !== 32'hC3A00000 || out_addr !== 32'h114) begin errors++; $display("FAIL reserved_mode_count0: got %h@%h expected C3A00000@00000114", out_data, out_addr); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL count0_done: got %b expected 1", done); end
    step();
  endtask

  task automatic test_branch_patch();
    base_load = 1'b1; base_addr = 32'h103;
    req_first = 7'h2C; req_count = 4'd1; req_pmode = 2'd2; req_pidx = 4'd0;
    req_imm = 12'h0; req_target = 32'h200; req_valid = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL base_load_priority: got ready=%b expected 1", req_ready); end
    base_load = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (out_data !== 32'hEB00003E || out_addr !== 32'h100) begin errors++; $display("FAIL branch_fwd: got %h@%h expected EB00003E@00000100", out_data, out_addr); end
    step(); step();
    base_load = 1'b1; base_addr = 32'h100;
    step();
    base_load = 1'b0;
    send_req(7'h2C, 4'd1, 2'd2, 4'd0, 12'h0, 32'h100);
    step();
    checks++; if (out_data !== 32'hEBFFFFFE || out_addr !== 32'h100) begin errors++; $display("FAIL branch_back: got %h@%h expected EBFFFFFE@00000100", out_data, out_addr); end
    step(); step();
  endtask

  task automatic test_back_pressure();
    int hs0;
    base_load = 1'b1; base_addr = 32'h200;
    step();
    base_load = 1'b0;
    hs0 = hs_cnt;
    send_req(7'h01, 4'd2, 2'd0, 4'd0, 12'h0, 32'h0);
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hE49D0004 || out_addr !== 32'h200) begin errors++; $display("FAIL bp_first: got v=%b %h@%h expected 1 E49D0004@00000200", out_valid, out_data, out_addr); end
    out_ready = 1'b0;
    base_load = 1'b1; base_addr = 32'h900;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hE49D0004 || out_addr !== 32'h200 || rom_addr !== 7'h02) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b %h@%h rom=%h expected 1 E49D0004@00000200 02", i, out_valid, out_data, out_addr, rom_addr);
      end
    end
    base_load = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hE52D0004 || out_addr !== 32'h204) begin errors++; $display("FAIL bp_second: got v=%b %h@%h expected 1 E52D0004@00000204", out_valid, out_data, out_addr); end
    step();
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_done: got done=%b valid=%b expected 1 0", done, out_valid); end
    step();
    checks++; if (hs_cnt - hs0 !== 2) begin errors++; $display("FAIL bp_handshakes: got %0d expected 2", hs_cnt - hs0); end
  endtask

  task automatic test_unmapped();
    base_load = 1'b1; base_addr = 32'h300;
    step();
    base_load = 1'b0;
    send_req(7'h42, 4'd2, 2'd0, 4'd0, 12'h0, 32'h0);
    step();
    checks++; if (out_data !== 32'hED800B00 || out_addr !== 32'h300 || err !== 1'b0) begin errors++; $display("FAIL unm_first: got %h@%h err=%b expected ED800B00@00000300 0", out_data, out_addr, err); end
    step();
    checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL unm_err: got err=%b valid=%b expected 1 0", err, out_valid); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL unm_done: got %b expected 1", done); end
    step();
    send_req(7'h01, 4'd1, 2'd0, 4'd0, 12'h0, 32'h0);
    step();
    checks++; if (out_addr !== 32'h304 || err !== 1'b1) begin errors++; $display("FAIL unm_counter: got addr=%h err=%b expected 00000304 1", out_addr, err); end
    step(); step();
  endtask

  task automatic test_reset_midrun();
    send_req(7'h01, 4'd3, 2'd0, 4'd0, 12'h0, 32'h0);
    step(); step();
    checks++; if (out_data !== 32'hE52D0004) begin errors++; $display("FAIL mid_second: got %h expected E52D0004", out_data); end
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL mid_reset: got valid=%b ready=%b err=%b expected 0 1 0", out_valid, req_ready, err); end
    rst = 1'b0;
    send_req(7'h01, 4'd1, 2'd0, 4'd0, 12'h0, 32'h0);
    step();
    checks++; if (out_addr !== 32'h0 || out_data !== 32'hE49D0004) begin errors++; $display("FAIL mid_counter: got %h@%h expected E49D0004@00000000", out_data, out_addr); end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_imm_patch();
    test_branch_patch();
    test_back_pressure();
    test_unmapped();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
